instr_mem_server: RTL and testbench

//  Instruction-side responder for the core's fetch interface: takes PC from the core and returns

---
 rtl/instr_mem_server_pkg.sv | 15 +
 rtl/instr_mem_server_if.sv | 30 +++
 rtl/instr_mem_server_packer.sv | 49 ++++
 rtl/instr_mem_server.sv | 90 +++++++++
 tb/tb_instr_mem_server.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_server_pkg.sv
// Shared types and constants for the instruction memory server: instruction word type,
// the NOP used as a safe fetch result, and the loader/run state encoding.
package instr_mem_server_pkg;

  typedef logic [31:0] instruction_t;

  localparam instruction_t NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instr_mem_server_if.sv
// Loader link plus fetch port of the instruction memory server. The master side is the
// external loader and the core; the slave side is the server.
interface instr_mem_server_if
  import instr_mem_server_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic              LOAD_START;
  logic              LOAD_VALID;
  logic [7:0]        LOAD_BYTE;
  logic              LOAD_READY;
  logic              LOAD_DONE;
  logic [31:0]       PC;
  instruction_t      INST;
  logic              INST_VALID;
  logic              FAULT;
  logic [ADDR_W:0]   WORDS_LOADED;

  modport master (
    output LOAD_START, LOAD_VALID, LOAD_BYTE, LOAD_DONE, PC,
    input  LOAD_READY, INST, INST_VALID, FAULT, WORDS_LOADED
  );

  modport slave (
    input  LOAD_START, LOAD_VALID, LOAD_BYTE, LOAD_DONE, PC,
    output LOAD_READY, INST, INST_VALID, FAULT, WORDS_LOADED
  );

endinterface

// File: rtl/instr_mem_server_packer.sv
// Assembles loader bytes little-endian into 32-bit words; a flush emits a partial word
// zero-padded in its upper bytes.
module instr_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        flush_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d, cnt_after;
  logic [31:0] asm_q, asm_d, merged;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    merged    = asm_q;
    cnt_after = cnt_q + {1'b0, byte_valid_i};
    if (byte_valid_i) merged[{cnt_q, 3'b000} +: 8] = byte_i;

    // A byte arriving with the flush lands in the word before it is emitted.
    word_valid_o = (byte_valid_i && (cnt_q == 2'd3)) || (flush_i && (cnt_after != 2'd0));
    word_o       = merged;

    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear_i || word_valid_o) begin
      cnt_d = 2'd0;
      asm_d = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_after;
      asm_d = merged;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/instr_mem_server.sv
// Instruction-side responder: byte-serial program loader filling a word memory, then a
// registered one-cycle-latency fetch port with misalignment/out-of-image fault reporting.
module instr_mem_server
  import instr_mem_server_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic               CLOCK,
  input logic               RESET_N,
  instr_mem_server_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W + 1)'(DEPTH);

  loader_state_t   state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic            in_load, not_full, load_ready;
  logic            byte_acc, flush, word_valid, mem_we;
  logic [31:0]     word;

  instruction_t    mem [DEPTH];
  instruction_t    rdata_q;
  logic            valid_q, fault_q;
  logic            fetch_en, fault_d;
  logic [ADDR_W-1:0] rd_idx;

  // LOAD_START restarts the load from any state and beats a simultaneous LOAD_DONE.
  always_comb begin
    state_d = state_q;
    if (bus.LOAD_START)                            state_d = LD_LOAD;
    else if (state_q == LD_LOAD && bus.LOAD_DONE)  state_d = LD_RUN;
  end

  always_comb begin
    in_load    = (state_q == LD_LOAD);
    not_full   = (wr_ptr_q != FULL_PTR);
    load_ready = in_load && not_full;
    byte_acc   = bus.LOAD_VALID && load_ready && !bus.LOAD_START;
    flush      = in_load && bus.LOAD_DONE && !bus.LOAD_START;
    mem_we     = word_valid && not_full;

    wr_ptr_d = wr_ptr_q;
    if (bus.LOAD_START) wr_ptr_d = '0;
    else if (mem_we)    wr_ptr_d = wr_ptr_q + 1'b1;

    // Fetch only while RUN persists across the edge, so outputs drop on the edge leaving RUN.
    fetch_en = (state_q == LD_RUN) && (state_d == LD_RUN);
    fault_d  = (bus.PC[1:0] != 2'b00) || (bus.PC[31:2] >= 30'(wr_ptr_q));
    rd_idx   = bus.PC[ADDR_W+1:2];
  end

  instr_byte_packer u_packer (
    .clk_i        (CLOCK),
    .rst_ni       (RESET_N),
    .clear_i      (bus.LOAD_START),
    .flush_i      (flush),
    .byte_valid_i (byte_acc),
    .byte_i       (bus.LOAD_BYTE),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q  <= LD_IDLE;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= fetch_en;
      fault_q  <= fetch_en && fault_d;
    end
  end

  // NOTE: the memory array and its read register carry no reset so they map onto RAM.
  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[wr_ptr_q[ADDR_W-1:0]] <= word;
    rdata_q <= mem[rd_idx];
  end

  assign bus.LOAD_READY   = load_ready;
  assign bus.INST         = (valid_q && !fault_q) ? rdata_q : NOP_INST;
  assign bus.INST_VALID   = valid_q;
  assign bus.FAULT        = fault_q;
  assign bus.WORDS_LOADED = wr_ptr_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Directed bench for instr_mem_server: loads programs, fetches through a scoreboard queue
// fed by a byte-level memory model, and exercises reset, restart and full-memory boundaries.
module tb_instr_mem_server;
  import instr_mem_server_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  int   checks = 0;
  int   failures = 0;

  exp_t        sb[$];
  logic [31:0] model_mem [256];
  int          model_words = 0;

  instr_mem_server_if #(.ADDR_W(8)) bus ();
  instr_mem_server_if #(.ADDR_W(2)) bus4 ();

  instr_mem_server #(.DEPTH(256), .ADDR_W(8)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  instr_mem_server #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus4.slave)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t exp_for(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    if (pc[1:0] != 2'b00 || (pc >> 2) >= 32'(model_words)) begin
      e.inst  = NOP_INST;
      e.fault = 1'b1;
    end else begin
      e.inst  = model_mem[pc[9:2]];
      e.fault = 1'b0;
    end
    return e;
  endfunction

  // Drives one PC, queues its expected result, and compares it one edge later.
  task automatic fetch(input logic [31:0] pc);
    exp_t e;
    sb.push_back(exp_for(pc));
    bus.PC = pc;
    tick();
    e = sb.pop_front();
    check($sformatf("inst@%h", e.pc), bus.INST, e.inst);
    check($sformatf("fault@%h", e.pc), 32'(bus.FAULT), 32'(e.fault));
    check($sformatf("valid@%h", e.pc), 32'(bus.INST_VALID), 32'd1);
  endtask

  // Start, stream bytes, finish with LOAD_DONE (optionally alongside the last byte).
  task automatic load_prog(input logic [7:0] b[$], input bit done_with_last);
    bus.LOAD_START = 1'b1;
    tick();
    bus.LOAD_START = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    foreach (b[i]) begin
      model_mem[i / 4][8 * (i % 4) +: 8] = b[i];
      bus.LOAD_VALID = 1'b1;
      bus.LOAD_BYTE  = b[i];
      bus.LOAD_DONE  = done_with_last && (i == b.size() - 1);
      tick();
    end
    bus.LOAD_VALID = 1'b0;
    if (!done_with_last) begin
      bus.LOAD_DONE = 1'b1;
      tick();
    end
    bus.LOAD_DONE = 1'b0;
    model_words   = (b.size() + 3) / 4;
  endtask

  initial begin
    logic [7:0] prog[$];
    int accepted;

    bus.LOAD_START = 0; bus.LOAD_VALID = 0; bus.LOAD_BYTE = 0; bus.LOAD_DONE = 0; bus.PC = 0;
    bus4.LOAD_START = 0; bus4.LOAD_VALID = 0; bus4.LOAD_BYTE = 0; bus4.LOAD_DONE = 0; bus4.PC = 0;

    tick();
    tick();
    check("rst_ready", 32'(bus.LOAD_READY), 32'd0);
    check("rst_inst", bus.INST, 32'h0000_0013);
    check("rst_valid", 32'(bus.INST_VALID), 32'd0);
    check("rst_fault", 32'(bus.FAULT), 32'd0);
    check("rst_words", 32'(bus.WORDS_LOADED), 32'd0);

    // LOAD_DONE in IDLE is ignored.
    RESET_N = 1'b1;
    bus.LOAD_DONE = 1'b1;
    tick();
    bus.LOAD_DONE = 1'b0;
    tick();
    check("idle_done_valid", 32'(bus.INST_VALID), 32'd0);
    check("idle_done_ready", 32'(bus.LOAD_READY), 32'd0);

    // Reset in the middle of a load after two bytes.
    bus.LOAD_START = 1'b1;
    tick();
    bus.LOAD_START = 1'b0;
    check("load_ready", 32'(bus.LOAD_READY), 32'd1);
    bus.LOAD_VALID = 1'b1; bus.LOAD_BYTE = 8'hAA;
    tick();
    bus.LOAD_BYTE = 8'hBB;
    tick();
    bus.LOAD_VALID = 1'b0;
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    check("midrst_ready", 32'(bus.LOAD_READY), 32'd0);
    check("midrst_words", 32'(bus.WORDS_LOADED), 32'd0);
    check("midrst_inst", bus.INST, 32'h0000_0013);
    check("midrst_valid", 32'(bus.INST_VALID), 32'd0);

    // Two-instruction program.
    prog = {8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    load_prog(prog, 1'b0);
    check("prog_words", 32'(bus.WORDS_LOADED), 32'd2);
    check("run_first_valid", 32'(bus.INST_VALID), 32'd0);
    check("model_w0", model_mem[0], 32'h0050_0093);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'h2);
    fetch(32'h4);
    fetch(32'h0000_0400);
    fetch(32'h8000_0000);

    // Five bytes with LOAD_DONE on the fifth: partial word zero-padded.
    prog = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    load_prog(prog, 1'b1);
    check("five_words", 32'(bus.WORDS_LOADED), 32'd2);
    check("model_w1", model_mem[1], 32'h0000_0005);
    bus.PC = 32'h0;
    tick();
    fetch(32'h8);
    fetch(32'h2);
    fetch(32'h4);
    fetch(32'h0);

    // LOAD_START with LOAD_DONE while in RUN: restart wins.
    bus.LOAD_START = 1'b1;
    bus.LOAD_DONE  = 1'b1;
    tick();
    bus.LOAD_START = 1'b0;
    bus.LOAD_DONE  = 1'b0;
    check("restart_words", 32'(bus.WORDS_LOADED), 32'd0);
    check("restart_valid", 32'(bus.INST_VALID), 32'd0);
    check("restart_inst", bus.INST, 32'h0000_0013);
    check("restart_ready", 32'(bus.LOAD_READY), 32'd1);
    bus.LOAD_DONE = 1'b1;
    tick();
    bus.LOAD_DONE = 1'b0;
    model_words = 0;
    tick();
    fetch(32'h0);

    // DEPTH=4 instance: 17 bytes with valid held, only 16 fit.
    bus4.LOAD_START = 1'b1;
    tick();
    bus4.LOAD_START = 1'b0;
    accepted = 0;
    for (int i = 0; i < 17; i++) begin
      bus4.LOAD_VALID = 1'b1;
      bus4.LOAD_BYTE  = 8'(i);
      if (bus4.LOAD_READY) accepted++;
      tick();
    end
    bus4.LOAD_VALID = 1'b0;
    check("full_accepted", 32'(accepted), 32'd16);
    check("full_ready", 32'(bus4.LOAD_READY), 32'd0);
    check("full_words", 32'(bus4.WORDS_LOADED), 32'd4);
    bus4.LOAD_DONE = 1'b1;
    tick();
    bus4.LOAD_DONE = 1'b0;
    bus4.PC = 32'hC;
    tick();
    check("full_inst12", bus4.INST, 32'h0F0E_0D0C);
    check("full_fault12", 32'(bus4.FAULT), 32'd0);
    bus4.PC = 32'h10;
    tick();
    check("full_inst16", bus4.INST, 32'h0000_0013);
    check("full_fault16", 32'(bus4.FAULT), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
